// File: rtl/pcfetch.sv
// Fetch-stage PC register and single-outstanding instruction-bus requester.
// Buffers one returned instruction for decode and drops responses made stale by a redirect.
module pcfetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_selected,
    input  logic        redirect,
    output logic [63:0] pc_plus4,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr,
    input  logic        d_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic [31:0] ibuf_q, ibuf_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ibuf_d     = ibuf_q;
        case (state_q)
            IDLE: begin
                req_addr_d = pc_q;
                state_d    = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_d = pc_selected;
                    // The bus needs a stable address until data_ok, so an
                    // unanswered request is drained via DISCARD instead.
                    if (iresp_data_ok) req_addr_d = pc_selected;
                    else               state_d    = DISCARD;
                end else if (iresp_data_ok) begin
                    ibuf_d  = iresp_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect || d_ready) begin
                    pc_d       = pc_selected;
                    req_addr_d = pc_selected;
                    state_d    = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) pc_d = pc_selected;
                if (iresp_data_ok) begin
                    req_addr_d = redirect ? pc_selected : pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            ibuf_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ibuf_q     <= ibuf_d;
        end
    end

    assign pc_plus4   = pc_q + 64'd4;
    assign ireq_valid = (state_q == FETCH) || (state_q == DISCARD);
    assign ireq_addr  = req_addr_q;
    assign f_valid    = (state_q == HOLD);
    assign f_pc       = pc_q;
    assign f_instr    = ibuf_q;

endmodule

// File: tb/tb_pcfetch.sv
// Self-checking bench for pcfetch: directed scenarios plus a randomized run
// compared against a bus-level reference model.
module tb_pcfetch;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk, reset;
    logic [63:0] pc_selected;
    logic        redirect;
    logic [63:0] pc_plus4;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        f_valid;
    logic [63:0] f_pc;
    logic [31:0] f_instr;
    logic        d_ready;

    int tests = 0;
    int fails = 0;

    pcfetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .pc_selected(pc_selected), .redirect(redirect),
        .pc_plus4(pc_plus4), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .d_ready(d_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what the fetch unit owes the bus and decode.
    logic [63:0] m_pc, m_addr;
    logic [31:0] m_instr;
    bit          m_started, m_busy, m_stale, m_hold;

    task automatic model_reset();
        m_pc = RST_PC; m_addr = RST_PC; m_instr = 32'h0;
        m_started = 0; m_busy = 0; m_stale = 0; m_hold = 0;
    endtask

    task automatic model_clock();
        if (!m_started) begin
            m_started = 1; m_busy = 1; m_addr = m_pc;
        end else if (m_hold) begin
            if (redirect || d_ready) begin
                m_pc = pc_selected; m_addr = pc_selected; m_hold = 0; m_busy = 1;
            end
        end else if (m_busy) begin
            if (iresp_data_ok) begin
                if (redirect) begin
                    m_pc = pc_selected; m_addr = pc_selected; m_stale = 0;
                end else if (m_stale) begin
                    m_stale = 0; m_addr = m_pc;
                end else begin
                    m_instr = iresp_data; m_hold = 1; m_busy = 0;
                end
            end else if (redirect) begin
                m_pc = pc_selected; m_stale = 1;
            end
        end
    endtask

    // One clock: apply inputs, advance model at the edge, settle 1 time unit.
    task automatic tick(input bit redir, input logic [63:0] sel, input bit ok,
                        input logic [31:0] data, input bit dr);
        redirect = redir; pc_selected = sel; iresp_data_ok = ok;
        iresp_data = data; d_ready = dr;
        @(posedge clk);
        if (!reset) model_clock();
        #1;
        redirect = 0; iresp_data_ok = 0; d_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; redirect = 0; pc_selected = 0; iresp_data_ok = 0;
        iresp_data = 0; d_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (ireq_valid !== 1'b0) begin fails++; $display("FAIL rst_ireq_valid got %0b want 0", ireq_valid); end
        tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL rst_f_valid got %0b want 0", f_valid); end
        tests++; if (f_pc !== RST_PC) begin fails++; $display("FAIL rst_f_pc got %h want %h", f_pc, RST_PC); end
        tests++; if (f_instr !== 32'h0) begin fails++; $display("FAIL rst_f_instr got %h want 0", f_instr); end
        tests++; if (pc_plus4 !== RST_PC + 64'd4) begin fails++; $display("FAIL rst_pc_plus4 got %h want %h", pc_plus4, RST_PC + 64'd4); end
        reset = 0;
        #1;
        tests++; if (ireq_valid !== 1'b0) begin fails++; $display("FAIL idle_ireq_valid got %0b want 0", ireq_valid); end
        tick(0, 0, 0, 0, 0);
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC) begin fails++; $display("FAIL first_req got v=%0b a=%h want v=1 a=%h", ireq_valid, ireq_addr, RST_PC); end
    endtask

    task automatic test_first_fetch();
        tick(0, 0, 1, 32'h0000_0013, 0);
        tests++; if (f_valid !== 1'b1 || f_pc !== RST_PC || f_instr !== 32'h13) begin fails++; $display("FAIL first_fetch got v=%0b pc=%h i=%h want v=1 pc=%h i=13", f_valid, f_pc, f_instr, RST_PC); end
        tests++; if (ireq_valid !== 1'b0) begin fails++; $display("FAIL first_fetch_ireq got %0b want 0", ireq_valid); end
    endtask

    task automatic test_decode_stall();
        for (int i = 0; i < 5; i++) begin
            tick(0, 64'h1234, 0, 32'hFFFF_FFFF, 0);
            tests++; if (f_valid !== 1'b1 || f_pc !== RST_PC || f_instr !== 32'h13 || ireq_valid !== 1'b0) begin
                fails++; $display("FAIL stall_%0d got fv=%0b pc=%h i=%h rv=%0b want fv=1 pc=%h i=13 rv=0", i, f_valid, f_pc, f_instr, ireq_valid, RST_PC);
            end
        end
        tick(0, pc_plus4, 0, 0, 1);
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004 || f_valid !== 1'b0) begin fails++; $display("FAIL advance got rv=%0b a=%h fv=%0b want rv=1 a=80000004 fv=0", ireq_valid, ireq_addr, f_valid); end
    endtask

    task automatic test_redirect_outstanding();
        tick(1, 64'h8000_0100, 0, 0, 0);
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004 || pc_plus4 !== 64'h8000_0104) begin fails++; $display("FAIL redir_pend got rv=%0b a=%h p4=%h want rv=1 a=80000004 p4=80000104", ireq_valid, ireq_addr, pc_plus4); end
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 0, 0);
            tests++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004) begin fails++; $display("FAIL redir_stable_%0d got rv=%0b a=%h want rv=1 a=80000004", i, ireq_valid, ireq_addr); end
        end
        tick(0, 0, 1, 32'hDEAD_BEEF, 0);
        tests++; if (f_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100) begin fails++; $display("FAIL redir_drop got fv=%0b rv=%0b a=%h want fv=0 rv=1 a=80000100", f_valid, ireq_valid, ireq_addr); end
        tick(0, 0, 1, 32'h0000_0093, 0);
        tests++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_0100 || f_instr !== 32'h93) begin fails++; $display("FAIL redir_target got v=%0b pc=%h i=%h want v=1 pc=80000100 i=93", f_valid, f_pc, f_instr); end
    endtask

    task automatic test_hold_redirect();
        tick(1, 64'h8000_0200, 0, 0, 1);
        tests++; if (f_valid !== 1'b0 || f_pc !== 64'h8000_0200 || ireq_addr !== 64'h8000_0200 || ireq_valid !== 1'b1) begin fails++; $display("FAIL hold_redir got fv=%0b pc=%h a=%h rv=%0b want fv=0 pc=a=80000200 rv=1", f_valid, f_pc, ireq_addr, ireq_valid); end
    endtask

    task automatic test_redirect_same_cycle();
        tick(1, 64'h8000_0300, 1, 32'hBAD0_BAD0, 0);
        tests++; if (f_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0300) begin fails++; $display("FAIL same_cyc got fv=%0b rv=%0b a=%h want fv=0 rv=1 a=80000300", f_valid, ireq_valid, ireq_addr); end
        // A DISCARD detour would swallow this response instead of presenting it.
        tick(0, 0, 1, 32'h0000_0033, 0);
        tests++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_0300 || f_instr !== 32'h33) begin fails++; $display("FAIL same_cyc_next got v=%0b pc=%h i=%h want v=1 pc=80000300 i=33", f_valid, f_pc, f_instr); end
    endtask

    task automatic test_pc_wrap();
        tick(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        tests++; if (pc_plus4 !== 64'h0) begin fails++; $display("FAIL wrap_p4 got %h want 0", pc_plus4); end
        tick(0, 0, 1, 32'h0000_0077, 0);
        tick(0, pc_plus4, 0, 0, 1);
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0) begin fails++; $display("FAIL wrap_req got rv=%0b a=%h want rv=1 a=0", ireq_valid, ireq_addr); end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 0, 0, 0);
        #2 reset = 1;
        #1;
        tests++; if (ireq_valid !== 1'b0 || f_pc !== RST_PC || f_valid !== 1'b0) begin fails++; $display("FAIL mid_rst got rv=%0b pc=%h fv=%0b want rv=0 pc=%h fv=0", ireq_valid, f_pc, f_valid, RST_PC); end
        model_reset();
        tick(0, 0, 1, 32'h1111_1111, 0);
        reset = 0;
        #1;
        tick(0, 0, 0, 0, 0);
        tests++; if (ireq_valid !== 1'b1 || ireq_addr !== RST_PC || f_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_req got rv=%0b a=%h fv=%0b want rv=1 a=%h fv=0", ireq_valid, ireq_addr, f_valid, RST_PC); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            bit redir, ok, dr;
            logic [63:0] sel;
            redir = ($urandom_range(0, 99) < 15);
            ok    = ireq_valid && ($urandom_range(0, 99) < 40);
            dr    = ($urandom_range(0, 99) < 50);
            sel   = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : pc_plus4;
            tick(redir, sel, ok, $urandom(), dr);
            tests++;
            if (ireq_valid !== m_busy || (m_busy && ireq_addr !== m_addr) || f_valid !== m_hold ||
                f_pc !== m_pc || f_instr !== m_instr || pc_plus4 !== m_pc + 64'd4) begin
                fails++; bad++;
                if (bad <= 5) $display("FAIL rand_%0d got rv=%0b a=%h fv=%0b pc=%h i=%h want rv=%0b a=%h fv=%0b pc=%h i=%h",
                    i, ireq_valid, ireq_addr, f_valid, f_pc, f_instr, m_busy, m_addr, m_hold, m_pc, m_instr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_decode_stall();
        test_redirect_outstanding();
        test_hold_redirect();
        test_redirect_same_cycle();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
